// File: rtl/t5_pkg.sv
// t5_pkg: shared definitions for the T5 fetch stage (state encoding,
// reset fetch address, skid entry layout).
package t5_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } t5_state_e;

    // Default first fetch address after reset (word aligned)
    localparam logic [31:0] T5_RESET_PC = 32'h0000_0000;

    // Skid entry: {word address [31:2], instruction word [31:0]}
    localparam int unsigned T5_SKID_W = 62;

endpackage

// File: rtl/t5_fetch_skid.sv
// t5_fetch_skid: one-entry skid buffer holding an acked fetch
// {word address, instruction} while decode is stalled.
module t5_fetch_skid
    import t5_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 unload,
    input  logic                 flush,
    input  logic [T5_SKID_W-1:0] din,
    output logic                 vld,
    output logic [T5_SKID_W-1:0] dout
);

    logic                 vld_d,  vld_q;
    logic [T5_SKID_W-1:0] data_d, data_q;

    // Next entry: load wins over unload, flush empties the entry last
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = din;
        end else if (unload) begin
            vld_d = 1'b0;
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    // Entry register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign dout = data_q;

endmodule

// File: rtl/t5_fetch.sv
// t5_fetch: Wishbone classic instruction fetch stage with a one-entry
// skid buffer and branch redirect (FLUSH waits out a pending ack).
// Optional macro T5_FETCH_ALIGN_EN: a redirect to a non word-aligned
// target raises fexc for one cycle and is otherwise ignored. Without it
// fexc stays 0 and bpc[1:0] is dropped.
// Valid/ready: the fetch register {fpc,fins} is handed over in every cycle
// where fvld=1 and sena=1; it may be reloaded when fvld=0 or sena=1.
module t5_fetch
    import t5_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = T5_RESET_PC
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic            btkn,
    input  logic [XLEN-1:0] bpc,
    output logic            iwb_cyc,
    output logic            iwb_stb,
    output logic [31:2]     iwb_adr,
    output logic [3:0]      iwb_sel,
    output logic            iwb_we,
    input  logic            iwb_ack,
    input  logic [XLEN-1:0] iwb_dat,
    output logic [XLEN-1:0] fpc,
    output logic [XLEN-1:0] fins,
    output logic            fvld,
    output logic            fexc,
    output t5_state_e       dbg_state
);

    t5_state_e       state_d, state_q;
    logic            stb_d,   stb_q;
    logic [29:0]     adr_d,   adr_q;
    logic [XLEN-1:0] fpc_d,   fpc_q;
    logic [XLEN-1:0] fins_d,  fins_q;
    logic            fvld_d,  fvld_q;
    logic            fexc_d,  fexc_q;
    logic [29:0]     tgt_d,   tgt_q;

    logic                 ack;
    logic                 loadable;
    logic                 misalign;
    logic                 redir;
    logic                 skid_load;
    logic                 skid_unload;
    logic                 skid_flush;
    logic                 skid_vld;
    logic [T5_SKID_W-1:0] skid_din;
    logic [T5_SKID_W-1:0] skid_dout;
    logic [29:0]          skid_adr;
    logic [XLEN-1:0]      skid_dat;

`ifdef T5_FETCH_ALIGN_EN
    assign misalign = btkn & (bpc[1:0] != 2'b00);
`else
    logic unused_bpc_lo;
    assign misalign      = 1'b0;
    assign unused_bpc_lo = ^bpc[1:0];
`endif

    // An ack only counts while our strobe is up (stale acks in IDLE/HOLD are dropped)
    assign ack      = iwb_ack & stb_q;
    assign loadable = ~fvld_q | sena;
    assign redir    = btkn & ~misalign;
    assign skid_din = {adr_q, iwb_dat};
    assign skid_adr = skid_dout[T5_SKID_W-1:XLEN];
    assign skid_dat = skid_dout[XLEN-1:0];

    t5_fetch_skid u_skid (
        .clk    (sclk),
        .rst    (srst),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .din    (skid_din),
        .vld    (skid_vld),
        .dout   (skid_dout)
    );

    // Next-state logic: redirect first, then the per-state fetch flow
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        fpc_d       = fpc_q;
        fins_d      = fins_q;
        fvld_d      = fvld_q & ~sena;
        fexc_d      = misalign;
        tgt_d       = tgt_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        if (redir) begin
            fvld_d     = 1'b0;
            skid_flush = 1'b1;
            if (state_q == ST_REQ && !ack) begin
                // Request still open: keep strobe, remember where to go
                state_d = ST_FLUSH;
                tgt_d   = bpc[31:2];
            end else if (state_q == ST_FLUSH && !ack) begin
                tgt_d = bpc[31:2];
            end else begin
                state_d = ST_REQ;
                stb_d   = 1'b1;
                adr_d   = bpc[31:2];
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                    stb_d   = 1'b1;
                    adr_d   = RESET_PC[31:2];
                end
                ST_REQ: begin
                    if (ack) begin
                        if (loadable) begin
                            fpc_d  = {adr_q, 2'b00};
                            fins_d = iwb_dat;
                            fvld_d = 1'b1;
                            adr_d  = adr_q + 30'd1;
                        end else begin
                            skid_load = 1'b1;
                            stb_d     = 1'b0;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sena && skid_vld) begin
                        fpc_d       = {skid_adr, 2'b00};
                        fins_d      = skid_dat;
                        fvld_d      = 1'b1;
                        skid_unload = 1'b1;
                        state_d     = ST_REQ;
                        stb_d       = 1'b1;
                        adr_d       = skid_adr + 30'd1;
                    end
                end
                ST_FLUSH: begin
                    if (ack) begin
                        state_d = ST_REQ;
                        adr_d   = tgt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stb_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM and output registers with synchronous reset
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            stb_q   <= 1'b0;
            adr_q   <= RESET_PC[31:2];
            fpc_q   <= RESET_PC;
            fins_q  <= '0;
            fvld_q  <= 1'b0;
            fexc_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            fpc_q   <= fpc_d;
            fins_q  <= fins_d;
            fvld_q  <= fvld_d;
            fexc_q  <= fexc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign iwb_cyc   = stb_q;
    assign iwb_stb   = stb_q;
    assign iwb_adr   = adr_q;
    assign iwb_sel   = 4'hF;
    assign iwb_we    = 1'b0;
    assign fpc       = fpc_q;
    assign fins      = fins_q;
    assign fvld      = fvld_q;
    assign fexc      = fexc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_t5_fetch.sv
// tb_t5_fetch: self-checking bench for t5_fetch with a wait-state
// Wishbone slave model and an expected-word queue of {fpc, fins}.
module tb_t5_fetch;
    import t5_pkg::*;

    // Clock / reset / DUT inputs
    logic        sclk  = 1'b0;
    logic        srst  = 1'b1;
    logic        sena  = 1'b0;
    logic        btkn  = 1'b0;
    logic [31:0] bpc   = 32'h0;

    // DUT outputs and slave response
    logic        iwb_cyc;
    logic        iwb_stb;
    logic [31:2] iwb_adr;
    logic [3:0]  iwb_sel;
    logic        iwb_we;
    logic        iwb_ack;
    logic [31:0] iwb_dat;
    logic [31:0] fpc;
    logic [31:0] fins;
    logic        fvld;
    logic        fexc;
    t5_state_e   dbg_state;

    // Scoreboard
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    bit          sb_en = 1'b0;

    // Slave controls
    int slv_wait      = 0;
    int slv_cnt       = 0;
    bit slv_const     = 1'b0;
    bit slv_force_ack = 1'b0;

    always #5 sclk = ~sclk;

    t5_fetch dut (
        .sclk      (sclk),
        .srst      (srst),
        .sena      (sena),
        .btkn      (btkn),
        .bpc       (bpc),
        .iwb_cyc   (iwb_cyc),
        .iwb_stb   (iwb_stb),
        .iwb_adr   (iwb_adr),
        .iwb_sel   (iwb_sel),
        .iwb_we    (iwb_we),
        .iwb_ack   (iwb_ack),
        .iwb_dat   (iwb_dat),
        .fpc       (fpc),
        .fins      (fins),
        .fvld      (fvld),
        .fexc      (fexc),
        .dbg_state (dbg_state)
    );

    function automatic logic [31:0] dat_of(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hC0DE_0000;
    endfunction

    // Slave: ack after slv_wait idle strobe cycles; data derived from address
    assign iwb_ack = slv_force_ack | (iwb_stb && (slv_cnt >= slv_wait));
    assign iwb_dat = slv_const ? 32'h0000_0013 : dat_of(iwb_adr);

    always @(posedge sclk) begin
        if (iwb_stb && !iwb_ack) slv_cnt <= slv_cnt + 1;
        else                     slv_cnt <= 0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard at negedge, return 1 time unit after posedge
    task automatic step();
        logic [63:0] e;
        @(negedge sclk);
        if (sb_en && fvld === 1'b1 && sena) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got fpc=%h fins=%h, expected no word", fpc, fins);
            end else begin
                e = exp_q.pop_front();
                if ({fpc, fins} !== e) begin
                    errors++;
                    $display("FAIL sb_word: got fpc=%h fins=%h, expected fpc=%h fins=%h",
                             fpc, fins, e[63:32], e[31:0]);
                end
            end
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({pc, slv_const ? 32'h0000_0013 : dat_of(pc[31:2])});
            pc = pc + 32'd4;
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            step();
        end
    endtask

    task automatic apply_reset();
        srst = 1'b1; sena = 1'b0; btkn = 1'b0; bpc = 32'h0;
        sb_en = 1'b0; slv_force_ack = 1'b0;
        exp_q.delete();
        step();
        step();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; sena = 1'b0; btkn = 1'b0; bpc = 32'h0;
        step();
        step();
        checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", iwb_stb); end
        checks++; if (iwb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", iwb_cyc); end
        checks++; if (iwb_adr !== 30'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", iwb_adr); end
        checks++; if (fpc !== 32'h0) begin errors++; $display("FAIL reset_fpc: got %h expected 0", fpc); end
        checks++; if (fins !== 32'h0) begin errors++; $display("FAIL reset_fins: got %h expected 0", fins); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL reset_fvld: got %b expected 0", fvld); end
        checks++; if (fexc !== 1'b0) begin errors++; $display("FAIL reset_fexc: got %b expected 0", fexc); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        checks++; if (iwb_sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h expected f", iwb_sel); end
        checks++; if (iwb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", iwb_we); end
        srst = 1'b0;
    endtask

    // Zero-wait slave, constant word, one instruction per cycle
    task automatic test_sequential();
        apply_reset();
        slv_const = 1'b1; slv_wait = 0;
        push_run(32'h0, 8);
        sb_en = 1'b1; sena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (iwb_adr !== 30'(i)) begin errors++; $display("FAIL seq_adr%0d: got %h expected %h", i, iwb_adr, i); end
            checks++; if (fvld !== (i >= 1)) begin errors++; $display("FAIL seq_fvld%0d: got %b expected %b", i, fvld, (i >= 1)); end
            if (i >= 1) begin
                checks++; if (fpc !== 32'((i - 1) * 4)) begin errors++; $display("FAIL seq_fpc%0d: got %h expected %h", i, fpc, (i - 1) * 4); end
            end
        end
        drain(40);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0; slv_const = 1'b0;
    endtask

    // Decode stall while an ack lands: skid then resume without loss
    task automatic test_stall();
        apply_reset();
        slv_wait = 0;
        push_run(32'h0, 12);
        sb_en = 1'b1; sena = 1'b1;
        repeat (5) step();
        sena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (dbg_state !== ST_HOLD) begin errors++; $display("FAIL stall_state%0d: got %0d expected %0d", i, dbg_state, ST_HOLD); end
            checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL stall_stb%0d: got %b expected 0", i, iwb_stb); end
            checks++; if ({fvld, fpc, fins} !== {1'b1, exp_q[0]}) begin
                errors++; $display("FAIL stall_freg%0d: got %b/%h/%h expected 1/%h/%h", i, fvld, fpc, fins, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        sena = 1'b1;
        drain(60);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0;
    endtask

    // Redirect while an ack is pending, plus a retarget inside FLUSH
    task automatic test_flush();
        bit found;
        apply_reset();
        slv_wait = 2; sena = 1'b1;
        repeat (4) step();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dbg_state == ST_REQ && iwb_stb && !iwb_ack) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL flush_pre: got no pending request, expected one"); end
        btkn = 1'b1; bpc = 32'h0000_0180; sena = 1'b0;
        push_run(32'h0000_0100, 6);
        sb_en = 1'b1;
        step();
        checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL flush_state: got %0d expected %0d", dbg_state, ST_FLUSH); end
        checks++; if (iwb_stb !== 1'b1) begin errors++; $display("FAIL flush_stb: got %b expected 1", iwb_stb); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL flush_fvld: got %b expected 0", fvld); end
        bpc = 32'h0000_0100;
        step();
        btkn = 1'b0; bpc = 32'h0; sena = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (dbg_state == ST_REQ) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL flush_exit: got state %0d, expected %0d", dbg_state, ST_REQ); end
        checks++; if (iwb_adr !== 30'h40) begin errors++; $display("FAIL flush_adr: got %h expected 40", iwb_adr); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL flush_fvld2: got %b expected 0", fvld); end
        drain(80);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0; slv_wait = 0;
    endtask

    // Redirect on the same edge as an ack
    task automatic test_same_cycle_ack();
        apply_reset();
        slv_wait = 0; sena = 1'b1;
        repeat (4) step();
        checks++; if (iwb_ack !== 1'b1) begin errors++; $display("FAIL sca_pre: got ack %b expected 1", iwb_ack); end
        btkn = 1'b1; bpc = 32'h0000_0200; sena = 1'b0;
        push_run(32'h0000_0200, 6);
        sb_en = 1'b1;
        step();
        checks++; if (iwb_adr !== 30'h80) begin errors++; $display("FAIL sca_adr: got %h expected 80", iwb_adr); end
        checks++; if (dbg_state !== ST_REQ) begin errors++; $display("FAIL sca_state: got %0d expected %0d", dbg_state, ST_REQ); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL sca_fvld: got %b expected 0", fvld); end
        btkn = 1'b0; bpc = 32'h0; sena = 1'b1;
        drain(40);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sca_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0;
    endtask

    // Reset mid-request with a slave that keeps acking through reset
    task automatic test_reset_mid();
        bit found;
        apply_reset();
        slv_wait = 3; sena = 1'b1;
        repeat (2) step();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (iwb_stb && !iwb_ack) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_pre: got no pending request, expected one"); end
        srst = 1'b1; slv_force_ack = 1'b1;
        step();
        checks++; if (iwb_stb !== 1'b0 || iwb_cyc !== 1'b0) begin errors++; $display("FAIL rmid_stb: got stb=%b cyc=%b expected 0/0", iwb_stb, iwb_cyc); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        step();
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL rmid_fvld: got %b expected 0", fvld); end
        srst = 1'b0;
        step();
        checks++; if (dbg_state !== ST_REQ || iwb_stb !== 1'b1) begin errors++; $display("FAIL rmid_restart: got state=%0d stb=%b expected %0d/1", dbg_state, iwb_stb, ST_REQ); end
        checks++; if (iwb_adr !== 30'h0) begin errors++; $display("FAIL rmid_adr: got %h expected 0", iwb_adr); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL rmid_ack_ignored: got fvld %b expected 0", fvld); end
        slv_force_ack = 1'b0;
        push_run(32'h0, 6);
        sb_en = 1'b1;
        drain(80);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0; slv_wait = 0;
    endtask

    // Redirect near the top of the address space: word address wraps to 0
    task automatic test_wrap();
        apply_reset();
        slv_wait = 0; sena = 1'b1;
        repeat (3) step();
        btkn = 1'b1; bpc = 32'hFFFF_FFF8; sena = 1'b0;
        push_run(32'hFFFF_FFF8, 5);
        sb_en = 1'b1;
        step();
        btkn = 1'b0; bpc = 32'h0; sena = 1'b1;
        drain(40);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0;
    endtask

`ifdef T5_FETCH_ALIGN_EN
    // Misaligned redirect: fexc pulse, sequential stream untouched
    task automatic test_misalign();
        apply_reset();
        slv_wait = 0;
        push_run(32'h0, 12);
        sb_en = 1'b1; sena = 1'b1;
        repeat (5) step();
        btkn = 1'b1; bpc = 32'h0000_0102; sena = 1'b0;
        step();
        checks++; if (fexc !== 1'b1) begin errors++; $display("FAIL mis_fexc: got %b expected 1", fexc); end
        checks++; if (dbg_state !== ST_HOLD || fvld !== 1'b1) begin errors++; $display("FAIL mis_state: got %0d/%b expected %0d/1", dbg_state, fvld, ST_HOLD); end
        btkn = 1'b0; bpc = 32'h0; sena = 1'b1;
        step();
        checks++; if (fexc !== 1'b0) begin errors++; $display("FAIL mis_fexc_off: got %b expected 0", fexc); end
        drain(60);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mis_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0;
    endtask
`else
    // Without the alignment check the low target bits are dropped
    task automatic test_misalign();
        apply_reset();
        slv_wait = 0; sena = 1'b1;
        repeat (5) step();
        btkn = 1'b1; bpc = 32'h0000_0102; sena = 1'b0;
        push_run(32'h0000_0100, 6);
        sb_en = 1'b1;
        step();
        checks++; if (fexc !== 1'b0) begin errors++; $display("FAIL trunc_fexc: got %b expected 0", fexc); end
        checks++; if (iwb_adr !== 30'h40) begin errors++; $display("FAIL trunc_adr: got %h expected 40", iwb_adr); end
        checks++; if (fvld !== 1'b0) begin errors++; $display("FAIL trunc_fvld: got %b expected 0", fvld); end
        btkn = 1'b0; bpc = 32'h0; sena = 1'b1;
        drain(40);
        sena = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL trunc_drain: %0d words left, expected 0", exp_q.size()); end
        sb_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_same_cycle_ack();
        test_reset_mid();
        test_wrap();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
